// File: rtl/ride_queue_pkg.sv
// ============================================================================
// ride_queue_pkg
// Shared constants for the ride queue controller: segment codes, op-select
// encoding and switch_pulse state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ride_queue_pkg;

   // Active-low segment patterns, bit order a..g from MSB to LSB
   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0001100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_RIDE = 3'd1,
      OP_ADD1 = 3'd2,
      OP_ADD2 = 3'd3,
      OP_ADD3 = 3'd4
   } op_sel_t;

   typedef enum logic [1:0] {
      SP_IDLE = 2'd0,
      SP_HELD = 2'd1,
      SP_FIRE = 2'd2
   } sp_state_t;

   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ride_queue_ctrl_switch_pulse.sv
// ============================================================================
// switch_pulse
// Qualifies a raw switch press (held >= HOLD_CYCLES) and emits one pulse
// the cycle after the release is seen.
// Revision: 1.0
// ============================================================================
`default_nettype none

module switch_pulse
   import ride_queue_pkg::*;
#(
   parameter int HOLD_CYCLES = 1000
) (
   input  logic CLOCK_50,
   input  logic rst,
   input  logic in,
   output logic pulse
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   sp_state_t         state_q;
   logic              in_q;
   logic [HOLD_W-1:0] hold_q;
   logic              pulse_q;

   // in_q registers the asynchronous switch before the FSM looks at it
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         in_q    <= 1'b0;
         state_q <= SP_IDLE;
         hold_q  <= '0;
         pulse_q <= 1'b0;
      end else begin
         in_q    <= in;
         pulse_q <= 1'b0;
         case (state_q)
            SP_IDLE: begin
               if (in_q) begin
                  state_q <= SP_HELD;
                  hold_q  <= '0;
               end
            end
            SP_HELD: begin
               if (in_q) begin
                  if (hold_q < HOLD_W'(HOLD_CYCLES)) hold_q <= hold_q + 1'b1;
               end else if (hold_q >= HOLD_W'(HOLD_CYCLES)) begin
                  state_q <= SP_FIRE;
                  pulse_q <= 1'b1;
               end else begin
                  state_q <= SP_IDLE;
               end
            end
            SP_FIRE: state_q <= SP_IDLE;
            default: state_q <= SP_IDLE;
         endcase
      end
   end

   assign pulse = pulse_q;

endmodule

`default_nettype wire

// File: rtl/ride_queue_ctrl.sv
// ============================================================================
// ride_queue_ctrl
// Waiting-line counter for one ride with debounced add/dispatch switches and
// a three-digit active-low 7-seg readout. Option macro: RIDE_QUEUE_OVERFLOW_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ride_queue_ctrl
   import ride_queue_pkg::*;
#(
   parameter int STEP        = 4,
   parameter int RIDE_CAP    = 8,
   parameter int MAX_COUNT   = 99,
   parameter int HOLD_CYCLES = 1000,
   parameter int CNT_W       = $clog2(MAX_COUNT + 1)
) (
   input  logic             CLOCK_50,
   input  logic             rst,
   input  logic [2:0]       sw_add,
   input  logic             sw_ride,
   output logic [CNT_W-1:0] wait_count,
   output logic [CNT_W-1:0] rides_avail,
   output logic             reject,
   output logic             overflow,
   output logic [0:6]       HEX0,
   output logic [0:6]       HEX1,
   output logic [0:6]       HEX3
);

   localparam int SUM_W = CNT_W + 2;

   logic [3:0]       sw_raw;
   logic [3:0]       pulse;
   op_sel_t          op_sel;
   logic [SUM_W-1:0] add_amt;
   logic [SUM_W-1:0] sum;
   logic             clamp;
   logic             is_add;
   logic [CNT_W-1:0] wait_count_q, wait_count_d;
   logic             reject_q, reject_d;

   assign sw_raw = {sw_ride, sw_add};

   generate
      for (genvar i = 0; i < 4; i++) begin : g_sw
         switch_pulse #(
            .HOLD_CYCLES(HOLD_CYCLES)
         ) u_switch_pulse (
            .CLOCK_50(CLOCK_50),
            .rst     (rst),
            .in      (sw_raw[i]),
            .pulse   (pulse[i])
         );
      end
   endgenerate

   always_comb begin
      op_sel = OP_NONE;
      if (pulse[3])      op_sel = OP_RIDE;
      else if (pulse[2]) op_sel = OP_ADD3;
      else if (pulse[1]) op_sel = OP_ADD2;
      else if (pulse[0]) op_sel = OP_ADD1;
   end

   always_comb begin
      add_amt = '0;
      case (op_sel)
         OP_ADD1: add_amt = SUM_W'(STEP);
         OP_ADD2: add_amt = SUM_W'(2 * STEP);
         OP_ADD3: add_amt = SUM_W'(3 * STEP);
         default: add_amt = '0;
      endcase
   end

   // Two guard bits keep the sum from wrapping before the clamp compare
   assign sum    = {2'b00, wait_count_q} + add_amt;
   assign clamp  = sum > SUM_W'(MAX_COUNT);
   assign is_add = (op_sel == OP_ADD1) || (op_sel == OP_ADD2) || (op_sel == OP_ADD3);

   always_comb begin
      wait_count_d = wait_count_q;
      reject_d     = 1'b0;
      if (op_sel == OP_RIDE) begin
         if (wait_count_q >= CNT_W'(RIDE_CAP)) wait_count_d = wait_count_q - CNT_W'(RIDE_CAP);
         else                                  reject_d     = 1'b1;
      end else if (is_add) begin
         wait_count_d = clamp ? CNT_W'(MAX_COUNT) : sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         wait_count_q <= '0;
         reject_q     <= 1'b0;
      end else begin
         wait_count_q <= wait_count_d;
         reject_q     <= reject_d;
      end
   end

`ifdef RIDE_QUEUE_OVERFLOW_EN
   logic overflow_q, overflow_d;

   assign overflow_d = overflow_q | (is_add & clamp);

   always_ff @(posedge CLOCK_50) begin
      if (rst) overflow_q <= 1'b0;
      else     overflow_q <= overflow_d;
   end

   assign overflow = overflow_q;
`else
   assign overflow = 1'b0;
`endif

   logic [7:0] wait8;
   logic [7:0] rides8;
   logic [3:0] ones_digit;
   logic [3:0] tens_digit;
   logic [3:0] rides_digit;

   assign wait_count  = wait_count_q;
   assign reject      = reject_q;
   assign rides_avail = wait_count_q / CNT_W'(RIDE_CAP);

   assign wait8       = 8'(wait_count_q);
   assign rides8      = 8'(rides_avail);
   assign ones_digit  = 4'(wait8 % 8'd10);
   assign tens_digit  = 4'(wait8 / 8'd10);
   assign rides_digit = (rides8 > 8'd9) ? 4'd9 : 4'(rides8);

   assign HEX0 = seg_decode(ones_digit);
   assign HEX1 = (wait8 < 8'd10) ? SEG_BLANK : seg_decode(tens_digit);
   assign HEX3 = seg_decode(rides_digit);

endmodule

`default_nettype wire

// File: tb/tb_ride_queue_ctrl.sv
// Directed table-driven bench for ride_queue_ctrl with HOLD_CYCLES=4.
`default_nettype none

module tb_ride_queue_ctrl;

   localparam int CNT_W = 7;
`ifdef RIDE_QUEUE_OVERFLOW_EN
   localparam int OVF_EN = 1;
`else
   localparam int OVF_EN = 0;
`endif

   logic             clk;
   logic             rst;
   logic [2:0]       sw_add;
   logic             sw_ride;
   logic [CNT_W-1:0] wait_count;
   logic [CNT_W-1:0] rides_avail;
   logic             reject;
   logic             overflow;
   logic [0:6]       HEX0, HEX1, HEX3;

   ride_queue_ctrl #(
      .STEP(4), .RIDE_CAP(8), .MAX_COUNT(99), .HOLD_CYCLES(4)
   ) dut (
      .CLOCK_50   (clk),
      .rst        (rst),
      .sw_add     (sw_add),
      .sw_ride    (sw_ride),
      .wait_count (wait_count),
      .rides_avail(rides_avail),
      .reject     (reject),
      .overflow   (overflow),
      .HEX0       (HEX0),
      .HEX1       (HEX1),
      .HEX3       (HEX3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int rej_cnt = 0;

   always @(negedge clk) if (reject === 1'b1) rej_cnt++;

   // digit 10 means blank
   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0001100;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic chk_outputs(input string tag, input int w, input int r, input int o,
                              input int t, input int rd, input int ovf);
      logic [6:0] h0, h1, h3;
      h0 = HEX0; h1 = HEX1; h3 = HEX3;
      chk({tag, " wait_count"},  int'(wait_count),  w);
      chk({tag, " rides_avail"}, int'(rides_avail), r);
      chk({tag, " HEX0"},        int'(h0), int'(seg_of(o)));
      chk({tag, " HEX1"},        int'(h1), int'(seg_of(t)));
      chk({tag, " HEX3"},        int'(h3), int'(seg_of(rd)));
      chk({tag, " overflow"},    int'(overflow), ovf * OVF_EN);
   endtask

   task automatic press(input logic [3:0] mask, input int hold);
      @(negedge clk);
      {sw_ride, sw_add} = mask;
      repeat (hold) @(negedge clk);
      {sw_ride, sw_add} = 4'b0000;
      repeat (6) @(negedge clk);
   endtask

   typedef struct {
      logic [3:0] mask;   // {ride, add2, add1, add0}
      int hold;
      int wait_c;
      int rides;
      int ones;
      int tens;
      int rdig;
      int rej;
      int ovf;
   } vec_t;

   vec_t vecs[22];

   initial begin
      int rej_before;
      vecs[0]  = '{4'b0010, 5,  8,  1, 8, 10, 1, 0, 0};
      vecs[1]  = '{4'b0001, 2,  8,  1, 8, 10, 1, 0, 0};
      vecs[2]  = '{4'b1000, 5,  0,  0, 0, 10, 0, 0, 0};
      vecs[3]  = '{4'b1000, 5,  0,  0, 0, 10, 0, 1, 0};
      vecs[4]  = '{4'b0100, 5, 12,  1, 2,  1, 1, 0, 0};
      vecs[5]  = '{4'b1000, 5,  4,  0, 4, 10, 0, 0, 0};
      vecs[6]  = '{4'b0001, 5,  8,  1, 8, 10, 1, 0, 0};
      vecs[7]  = '{4'b0010, 5, 16,  2, 6,  1, 2, 0, 0};
      vecs[8]  = '{4'b1100, 5,  8,  1, 8, 10, 1, 0, 0};
      vecs[9]  = '{4'b0100, 5, 20,  2, 0,  2, 2, 0, 0};
      vecs[10] = '{4'b0100, 5, 32,  4, 2,  3, 4, 0, 0};
      vecs[11] = '{4'b0100, 5, 44,  5, 4,  4, 5, 0, 0};
      vecs[12] = '{4'b0100, 5, 56,  7, 6,  5, 7, 0, 0};
      vecs[13] = '{4'b0100, 5, 68,  8, 8,  6, 8, 0, 0};
      vecs[14] = '{4'b0100, 5, 80, 10, 0,  8, 9, 0, 0};
      vecs[15] = '{4'b0100, 5, 92, 11, 2,  9, 9, 0, 0};
      vecs[16] = '{4'b0001, 5, 96, 12, 6,  9, 9, 0, 0};
      vecs[17] = '{4'b0100, 5, 99, 12, 9,  9, 9, 0, 1};
      vecs[18] = '{4'b1000, 5, 91, 11, 1,  9, 9, 0, 1};
      vecs[19] = '{4'b0010, 3, 91, 11, 1,  9, 9, 0, 1};
      vecs[20] = '{4'b0001, 4, 91, 11, 1,  9, 9, 0, 1};
      vecs[21] = '{4'b0001, 5, 95, 11, 5,  9, 9, 0, 1};

      rst = 1'b1;
      sw_add = 3'b000;
      sw_ride = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_outputs("reset", 0, 0, 0, 10, 0, 0);
      chk("reset reject", int'(reject), 0);

      for (int i = 0; i < 22; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         rej_before = rej_cnt;
         press(vecs[i].mask, vecs[i].hold);
         chk_outputs(tag, vecs[i].wait_c, vecs[i].rides, vecs[i].ones,
                     vecs[i].tens, vecs[i].rdig, vecs[i].ovf);
         chk({tag, " reject cycles"}, rej_cnt - rej_before, vecs[i].rej);
      end

      // Reset while add[0] is mid-hold; keep holding briefly after reset
      rej_before = rej_cnt;
      @(negedge clk);
      sw_add = 3'b001;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_outputs("in_reset", 0, 0, 0, 10, 0, 0);
      @(negedge clk);
      sw_add = 3'b000;
      repeat (6) @(negedge clk);
      chk_outputs("post_reset", 0, 0, 0, 10, 0, 0);
      chk("post_reset reject cycles", rej_cnt - rej_before, 0);

      // A full press after the reset still works normally
      press(4'b0001, 5);
      chk_outputs("after_reset_add", 4, 0, 4, 10, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
